// File: rtl/multicycle_control_unit_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, ALU op codes, FSM encoding.
// The TRAP state only exists when CTRL_ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_OR   = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
`ifdef CTRL_ILLEGAL_TRAP_EN
    , TRAP = 3'd5
`endif
  } state_t;

  // alt selects SUB for funct3=0 and SRA for funct3=5; callers mask it where it must not apply.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (funct3)
      3'd0: op = alt ? ALU_SUB : ALU_ADD;
      3'd1: op = ALU_SLL;
      3'd2: op = ALU_SLT;
      3'd3: op = ALU_SLTU;
      3'd4: op = ALU_XOR;
      3'd5: op = alt ? ALU_SRA : ALU_SRL;
      3'd6: op = ALU_OR;
      3'd7: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Memory handshake and datapath control bundle of the multi-cycle control unit.
// master = control unit side, slave = memories/datapath side.
interface multicycle_control_unit_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [31:0]           instr;
  logic                  imem_ready;
  logic                  dmem_ready;
  logic                  imem_req;
  logic                  ir_we;
  logic                  pc_we;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  alu_src_imm;
  logic                  wb_sel;
  logic                  we;
  logic                  mem_err;
  logic                  illegal_instr;
  logic [2:0]            state_o;

  modport master (
    input  instr, imem_ready, dmem_ready,
    output imem_req, ir_we, pc_we, dmem_req, dmem_we, alu_ctrl, alu_src_imm,
           wb_sel, we, mem_err, illegal_instr, state_o
  );

  modport slave (
    output instr, imem_ready, dmem_ready,
    input  imem_req, ir_we, pc_we, dmem_req, dmem_we, alu_ctrl, alu_src_imm,
           wb_sel, we, mem_err, illegal_instr, state_o
  );
endinterface

// File: rtl/multicycle_control_unit_instr_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into ALU control and instruction class.
// Unknown opcodes flag illegal and leave every control field at 0.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_src_imm,
  output logic                  wb_sel,
  output logic                  is_mem,
  output logic                  is_store,
  output logic                  illegal
);

  always_comb begin
    alu_ctrl    = '0;
    alu_src_imm = 1'b0;
    wb_sel      = 1'b0;
    is_mem      = 1'b0;
    is_store    = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_RTYPE: alu_ctrl = ALU_CTRL_W'(alu_from_funct(funct3, funct7_5));
      // Immediate bits overlap funct7, so bit 30 only means SRAI; ADDI never becomes SUB.
      OP_ITYPE: begin
        alu_ctrl    = ALU_CTRL_W'(alu_from_funct(funct3, funct7_5 && (funct3 == 3'd5)));
        alu_src_imm = 1'b1;
      end
      OP_LOAD: begin
        alu_ctrl    = ALU_CTRL_W'(ALU_ADD);
        alu_src_imm = 1'b1;
        wb_sel      = 1'b1;
        is_mem      = 1'b1;
      end
      OP_STORE: begin
        alu_ctrl    = ALU_CTRL_W'(ALU_ADD);
        alu_src_imm = 1'b1;
        is_mem      = 1'b1;
        is_store    = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake timeout.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of treating them as NOPs.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int TIMEOUT    = 16
) (
  input logic                       clk,
  input logic                       rst,
  multicycle_control_unit_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t state, state_next;

  logic [ALU_CTRL_W-1:0] d_alu, dec_alu;
  logic d_imm, d_wb, d_mem, d_store, d_ill;
  logic dec_imm, dec_wb, dec_mem, dec_store, dec_ill, dec_rd_zero;

  logic [CNT_W-1:0] wait_cnt;
  logic waiting, limit_hit, timed_out;
  logic imem_req, ir_we, pc_we, dmem_req, dmem_we, we, mem_err;
  logic unused_bits;

  assign unused_bits = ^{bus.instr[31], bus.instr[29:15]};

  instr_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_dec (
    .opcode      (bus.instr[6:0]),
    .funct3      (bus.instr[14:12]),
    .funct7_5    (bus.instr[30]),
    .alu_ctrl    (d_alu),
    .alu_src_imm (d_imm),
    .wb_sel      (d_wb),
    .is_mem      (d_mem),
    .is_store    (d_store),
    .illegal     (d_ill)
  );

  assign waiting   = ((state == FETCH) && !bus.imem_ready) || ((state == MEM) && !bus.dmem_ready);
  assign limit_hit = (TIMEOUT != 0) && (wait_cnt == LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // Decoded controls are captured once per instruction and held until the next DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_alu     <= '0;
      dec_imm     <= 1'b0;
      dec_wb      <= 1'b0;
      dec_mem     <= 1'b0;
      dec_store   <= 1'b0;
      dec_ill     <= 1'b0;
      dec_rd_zero <= 1'b0;
    end else if (state == DECODE) begin
      dec_alu     <= d_alu;
      dec_imm     <= d_imm;
      dec_wb      <= d_wb;
      dec_mem     <= d_mem;
      dec_store   <= d_store;
      dec_ill     <= d_ill;
      dec_rd_zero <= (bus.instr[11:7] == 5'd0);
    end
  end

  // A FETCH timeout re-enters FETCH without a state change, so clear on timeout too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        wait_cnt <= '0;
    else if (timed_out || (state_next != state))    wait_cnt <= '0;
    else if (waiting)                               wait_cnt <= wait_cnt + 1'b1;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    we         = 1'b0;
    mem_err    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we      = 1'b1;
          state_next = DECODE;
        end else if (limit_hit) begin
          mem_err   = 1'b1;
          timed_out = 1'b1;
        end
      end
      DECODE: state_next = EXEC;
      EXEC: begin
        if (dec_ill) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_next = TRAP;
`else
          pc_we      = 1'b1;
          state_next = FETCH;
`endif
        end else if (dec_mem) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_store;
        if (bus.dmem_ready) begin
          pc_we      = dec_store;
          state_next = dec_store ? FETCH : WB;
        end else if (limit_hit) begin
          mem_err    = 1'b1;
          timed_out  = 1'b1;
          state_next = FETCH;
        end
      end
      WB: begin
        we         = !dec_rd_zero;
        pc_we      = 1'b1;
        state_next = FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: state_next = TRAP;
`endif
      default: state_next = FETCH;
    endcase
    // The FSM already sits in FETCH during reset; mask strobes so nothing fires until release.
    if (rst) begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      we       = 1'b0;
      mem_err  = 1'b0;
    end
  end

  assign bus.imem_req    = imem_req;
  assign bus.ir_we       = ir_we;
  assign bus.pc_we       = pc_we;
  assign bus.dmem_req    = dmem_req;
  assign bus.dmem_we     = dmem_we;
  assign bus.we          = we;
  assign bus.mem_err     = mem_err;
  assign bus.alu_ctrl    = dec_alu;
  assign bus.alu_src_imm = dec_imm;
  assign bus.wb_sel      = dec_wb;
  assign bus.state_o     = state;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal_instr = (state == TRAP) && !rst;
`else
  assign bus.illegal_instr = 1'b0;
`endif

endmodule
